// File: rtl/mac_array_drain.sv
// Drains one row of MAC accumulators: parallel snapshot, per-column requantize
// (rounding arithmetic shift plus saturation), then valid/ready stream out.
module mac_array_drain #(
    parameter int NUM_COLS               = 4,
    parameter int ACCUMULATOR_DATA_WIDTH = 16,
    parameter int OUT_DATA_WIDTH         = 8,
    parameter int SHIFT_WIDTH            = 4,
    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       drain_start,
    input  logic [SHIFT_WIDTH-1:0]                     shift,
    input  logic [NUM_COLS*ACCUMULATOR_DATA_WIDTH-1:0] acc_in,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [OUT_DATA_WIDTH-1:0]                  out_data,
    output logic [CW-1:0]                              out_col,
    output logic                                       out_last,
    output logic                                       busy,
    output logic                                       done
);
    localparam int AW = ACCUMULATOR_DATA_WIDTH;
    localparam int OW = OUT_DATA_WIDTH;
    localparam logic signed [AW:0] SAT_MAX = (AW+1)'((1 << (OW-1)) - 1);
    localparam logic signed [AW:0] SAT_MIN = ~SAT_MAX;
    localparam logic [CW-1:0] LAST_COL = CW'(NUM_COLS - 1);

    // Handshake: a word moves on any rising edge where out_valid and out_ready
    // are both high; while out_ready is low the presented word holds stable.
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                 state;
    logic signed [AW-1:0]   snap [NUM_COLS];
    logic [SHIFT_WIDTH-1:0] shift_reg;
    logic [CW-1:0]          count;

    // One guard bit of headroom keeps the rounding add from overflowing.
    function automatic logic [OW-1:0] requant(input logic signed [AW-1:0] a,
                                              input logic [SHIFT_WIDTH-1:0] s);
        logic signed [AW:0] ext;
        logic signed [AW:0] rnd;
        logic signed [AW:0] r;
        ext = {a[AW-1], a};
        rnd = '0;
        if (s == '0) begin
            r = ext;
        end else if (int'(s) >= AW) begin
            r = {(AW+1){a[AW-1]}};
        end else begin
            rnd = (AW+1)'(1) << (s - 1'b1);
            r   = (ext + rnd) >>> s;
        end
        if (r > SAT_MAX)      r = SAT_MAX;
        else if (r < SAT_MIN) r = SAT_MIN;
        return r[OW-1:0];
    endfunction

    assign out_col  = count;
    assign out_data = out_valid ? requant(snap[count], shift_reg) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            for (int i = 0; i < NUM_COLS; i++) snap[i] <= '0;
            shift_reg <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (drain_start) begin
                        for (int i = 0; i < NUM_COLS; i++) snap[i] <= acc_in[i*AW +: AW];
                        shift_reg <= shift;
                        count     <= '0;
                        out_valid <= 1'b1;
                        out_last  <= (NUM_COLS == 1);
                        busy      <= 1'b1;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (count == LAST_COL) begin
                            count     <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            count    <= count + 1'b1;
                            out_last <= ((count + 1'b1) == LAST_COL);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
